// File: rtl/pingpong_bram_reader_if.sv
// Bundles the reader's bank handshakes, both BRAM read ports and the output stream.
// m_cksum exists only when READER_CKSUM_EN is defined.
interface pingpong_bram_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              bank_rdy_1;
    logic              bank_rdy_2;
    logic              rd_en_1;
    logic [ADDR_W-1:0] rd_add_1;
    logic [DATA_W-1:0] rd_data_1;
    logic              rd_en_2;
    logic [ADDR_W-1:0] rd_add_2;
    logic [DATA_W-1:0] rd_data_2;
    logic              bank_free_1;
    logic              bank_free_2;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;
    logic              busy;
    logic              overrun;
    logic [1:0]        dbg_state;
`ifdef READER_CKSUM_EN
    logic [DATA_W-1:0] m_cksum;
`endif

    // Stream handshake: a word transfers in every cycle where m_valid && m_ready;
    // while m_valid && !m_ready the reader holds m_data/m_last unchanged.
    modport master (
        input  bank_rdy_1, bank_rdy_2, rd_data_1, rd_data_2, m_ready,
        output rd_en_1, rd_add_1, rd_en_2, rd_add_2, bank_free_1, bank_free_2,
        output m_valid, m_data, m_last, busy, overrun, dbg_state
`ifdef READER_CKSUM_EN
        , output m_cksum
`endif
    );

    modport slave (
        output bank_rdy_1, bank_rdy_2, rd_data_1, rd_data_2, m_ready,
        input  rd_en_1, rd_add_1, rd_en_2, rd_add_2, bank_free_1, bank_free_2,
        input  m_valid, m_data, m_last, busy, overrun, dbg_state
`ifdef READER_CKSUM_EN
        , input m_cksum
`endif
    );
endinterface

// File: rtl/pingpong_bram_reader.sv
// Drains completed ping-pong BRAM banks in alternation onto a valid/ready stream,
// hiding BRAM read latency with a 2-entry buffer. Define READER_CKSUM_EN for m_cksum.
module pingpong_bram_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    pingpong_bram_reader_if.master  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FREE  = 2'd3
    } state_e;

    state_e            state_q;
    logic              sel_q;          // 0 = BRAM1, 1 = BRAM2
    logic              last_served_q;
    logic              pend1_q, pend2_q;
    logic              pend1_d, pend2_d;
    logic              overrun_q;
    logic [IDX_W-1:0]  rd_idx_q;
    logic [ADDR_W-1:0] rd_add1_q, rd_add2_q;
    logic              infl_q, infl_last_q;
    logic [DATA_W-1:0] buf_data_q [2];
    logic [1:0]        buf_last_q;
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q;

    logic              active1, active2;
    logic              ovr1, ovr2, set1, set2, avail1, avail2;
    logic              pick_valid, pick_sel;
    logic              pop, issue;
    logic [ADDR_W-1:0] idx_ext;
    logic [DATA_W-1:0] cap_data;
    logic [DATA_W-1:0] head_data;
    logic              head_last;

    // A bank owned by the FSM (any non-idle state) may not be re-announced.
    assign active1 = (state_q != ST_IDLE) && !sel_q;
    assign active2 = (state_q != ST_IDLE) &&  sel_q;
    assign ovr1    = bus.bank_rdy_1 && (pend1_q || active1);
    assign ovr2    = bus.bank_rdy_2 && (pend2_q || active2);
    assign set1    = bus.bank_rdy_1 && !ovr1;
    assign set2    = bus.bank_rdy_2 && !ovr2;
    assign avail1  = pend1_q || set1;
    assign avail2  = pend2_q || set2;

    assign pick_valid = (state_q == ST_IDLE) && (avail1 || avail2);
    assign pick_sel   = (avail1 && avail2) ? !last_served_q : avail2;
    assign pend1_d    = avail1 && !(pick_valid && !pick_sel);
    assign pend2_d    = avail2 && !(pick_valid &&  pick_sel);

    assign head_data = buf_data_q[rd_ptr_q];
    assign head_last = buf_last_q[rd_ptr_q];
    assign pop       = (count_q != 2'd0) && bus.m_ready;

    // Occupancy after this cycle's pop, plus the word still in the BRAM pipe, must leave a slot.
    assign issue = (state_q == ST_READ) &&
                   (({1'b0, count_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop}));

    assign idx_ext  = ADDR_W'(rd_idx_q);
    assign cap_data = sel_q ? bus.rd_data_2 : bus.rd_data_1;

    assign bus.rd_en_1     = issue && !sel_q;
    assign bus.rd_en_2     = issue &&  sel_q;
    assign bus.rd_add_1    = (issue && !sel_q) ? idx_ext : rd_add1_q;
    assign bus.rd_add_2    = (issue &&  sel_q) ? idx_ext : rd_add2_q;
    assign bus.bank_free_1 = (state_q == ST_FREE) && !sel_q;
    assign bus.bank_free_2 = (state_q == ST_FREE) &&  sel_q;
    assign bus.m_valid     = (count_q != 2'd0);
    assign bus.m_data      = head_data;
    assign bus.m_last      = head_last;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.overrun     = overrun_q;
    assign bus.dbg_state   = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sel_q         <= 1'b0;
            last_served_q <= 1'b1;
            pend1_q       <= 1'b0;
            pend2_q       <= 1'b0;
            overrun_q     <= 1'b0;
            rd_idx_q      <= '0;
            rd_add1_q     <= '0;
            rd_add2_q     <= '0;
            infl_q        <= 1'b0;
            infl_last_q   <= 1'b0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            buf_last_q    <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
            end
        end else begin
            pend1_q   <= pend1_d;
            pend2_q   <= pend2_d;
            overrun_q <= overrun_q || ovr1 || ovr2;

            infl_q <= issue;
            if (issue) begin
                infl_last_q <= (rd_idx_q == LAST_IDX);
                if (sel_q) begin
                    rd_add2_q <= idx_ext;
                end else begin
                    rd_add1_q <= idx_ext;
                end
            end

            // The BRAM word read last cycle lands in the buffer now.
            if (infl_q) begin
                buf_data_q[wr_ptr_q] <= cap_data;
                buf_last_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(infl_q) - 2'(pop);

            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        sel_q    <= pick_sel;
                        rd_idx_q <= '0;
                        state_q  <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        if (rd_idx_q == LAST_IDX) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            rd_idx_q <= rd_idx_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((count_q == 2'd0) && !infl_q) begin
                        state_q <= ST_FREE;
                    end
                end
                ST_FREE: begin
                    last_served_q <= sel_q;
                    state_q       <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef READER_CKSUM_EN
    logic [DATA_W-1:0] ck_acc_q;
    logic              ck_first_q;
    logic [DATA_W-1:0] ck_base;

    // ck_first_q marks that the head word opens a new frame, so earlier frames drop out.
    assign ck_base     = ck_first_q ? '0 : ck_acc_q;
    assign bus.m_cksum = ck_base ^ head_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            ck_acc_q   <= '0;
            ck_first_q <= 1'b1;
        end else if (pop) begin
            ck_acc_q   <= ck_base ^ head_data;
            ck_first_q <= head_last;
        end
    end
`endif
endmodule

// File: tb/tb_pingpong_bram_reader.sv
// Directed bench for pingpong_bram_reader: BRAM models return addr+100 / addr+200,
// a scoreboard queue holds expected {last, data} beats in acceptance order.
module tb_pingpong_bram_reader;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pingpong_bram_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    pingpong_bram_reader #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [DATA_W:0]  exp_q[$];
    int               free1_cnt, free2_cnt, rd_en2_cnt, acc_cnt, n_out, max_out;
    logic             prev_stall;
    logic [DATA_W:0]  prev_beat;
    logic [3:0]       ready_pat = 4'b1001;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- BRAM models (1-cycle read latency)
    always @(posedge clk) begin
        if (rst) begin
            bus.rd_data_1 <= '0;
            bus.rd_data_2 <= '0;
        end else begin
            if (bus.rd_en_1) bus.rd_data_1 <= DATA_W'(bus.rd_add_1) + DATA_W'(100);
            if (bus.rd_en_2) bus.rd_data_2 <= DATA_W'(bus.rd_add_2) + DATA_W'(200);
        end
    end

    // ---------------- scoreboard / monitor, sampled on the falling edge
    always @(negedge clk) begin
        logic            pop;
        logic [DATA_W:0] exp;
        pop = bus.m_valid && bus.m_ready;
        if (rst) begin
            n_out      = 0;
            prev_stall = 1'b0;
        end else begin
            if (bus.rd_en_2)     rd_en2_cnt++;
            if (bus.bank_free_1) free1_cnt++;
            if (bus.bank_free_2) free2_cnt++;
            if (prev_stall) begin
                check("stall_valid", bus.m_valid, 1);
                check("stall_beat", {bus.m_last, bus.m_data}, prev_beat);
            end
            if (pop) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", {bus.m_last, bus.m_data}, 64'hDEAD);
                end else begin
                    exp = exp_q.pop_front();
                    check("word", {bus.m_last, bus.m_data}, exp);
                    acc_cnt++;
`ifdef READER_CKSUM_EN
                    // XOR of 100..115 and of 200..215 are both zero
                    if (exp[DATA_W]) check("cksum", bus.m_cksum, 0);
`endif
                end
            end
            n_out = n_out + int'(bus.rd_en_1) + int'(bus.rd_en_2) - int'(pop);
            if (n_out > max_out) max_out = n_out;
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_beat  = {bus.m_last, bus.m_data};
        end
    end

    // ---------------- driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic clear_counters();
        free1_cnt  = 0;
        free2_cnt  = 0;
        rd_en2_cnt = 0;
        acc_cnt    = 0;
        max_out    = 0;
    endtask

    task automatic push_frame(input int base);
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back({(i == DEPTH - 1), DATA_W'(base + i)});
        end
    endtask

    task automatic pulse_rdy(input logic b1, input logic b2);
        bus.bank_rdy_1 = b1;
        bus.bank_rdy_2 = b2;
        tick();
        bus.bank_rdy_1 = 1'b0;
        bus.bank_rdy_2 = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit toggle);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            if (toggle) bus.m_ready = ready_pat[c % 4];
            tick();
            if (exp_q.size() == 0 && !bus.busy) done = 1'b1;
        end
        bus.m_ready = 1'b1;
        check(tag, done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.bank_rdy_1 = 1'b0;
        bus.bank_rdy_2 = 1'b0;
        bus.m_ready    = 1'b1;
        clear_counters();
        reset_dut();

        // reset state
        @(negedge clk);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rd_en_1", bus.rd_en_1, 0);
        check("rst_rd_en_2", bus.rd_en_2, 0);
        check("rst_rd_add_1", bus.rd_add_1, 0);
        check("rst_rd_add_2", bus.rd_add_2, 0);
        check("rst_free_1", bus.bank_free_1, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_m_last", bus.m_last, 0);

        // single BRAM1 frame, latency and full rate
        tick();
        clear_counters();
        push_frame(100);
        pulse_rdy(1'b1, 1'b0);
        @(negedge clk);
        check("t1_rd_en_first", bus.rd_en_1, 1);
        check("t1_rd_add_first", bus.rd_add_1, 0);
        check("t1_lat_c1", bus.m_valid, 0);
        @(negedge clk);
        check("t1_lat_c2", bus.m_valid, 0);
        @(negedge clk);
        check("t1_lat_c3", bus.m_valid, 1);
        for (int i = 1; i < DEPTH; i++) begin
            @(negedge clk);
            check("t1_full_rate", bus.m_valid, 1);
        end
        wait_done("t1_done", 1'b0);
        check("t1_free1_cnt", free1_cnt, 1);
        check("t1_free2_cnt", free2_cnt, 0);
        check("t1_rd_en2_cnt", rd_en2_cnt, 0);
        check("t1_busy", bus.busy, 0);

        // both banks ready together, from reset: BRAM1 first
        reset_dut();
        clear_counters();
        push_frame(100);
        push_frame(200);
        pulse_rdy(1'b1, 1'b1);
        wait_done("t2_done", 1'b0);
        check("t2_free1_cnt", free1_cnt, 1);
        check("t2_free2_cnt", free2_cnt, 1);
        check("t2_overrun", bus.overrun, 0);

        // back-pressure with m_ready pattern 1,0,0,1
        clear_counters();
        push_frame(100);
        pulse_rdy(1'b1, 1'b0);
        wait_done("t3_done", 1'b1);
        check("t3_free1_cnt", free1_cnt, 1);
        check("t3_max_outstanding_le2", (max_out <= 2), 1);

        // overrun: second BRAM1 pulse while BRAM1 is being read
        clear_counters();
        push_frame(100);
        pulse_rdy(1'b1, 1'b0);
        repeat (3) tick();
        check("t4_overrun_before", bus.overrun, 0);
        pulse_rdy(1'b1, 1'b0);
        check("t4_overrun_set", bus.overrun, 1);
        wait_done("t4_done", 1'b0);
        repeat (10) tick();
        check("t4_free1_cnt", free1_cnt, 1);
        check("t4_overrun_sticky", bus.overrun, 1);
        check("t4_idle_busy", bus.busy, 0);

        // reset in the middle of a BRAM2 frame
        clear_counters();
        push_frame(200);
        pulse_rdy(1'b0, 1'b1);
        for (int c = 0; c < 60 && acc_cnt < 6; c++) tick();
        check("t5_reached_word5", (acc_cnt >= 6), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        clear_counters();
        @(negedge clk);
        check("t5_m_valid", bus.m_valid, 0);
        check("t5_busy", bus.busy, 0);
        check("t5_rd_en_2", bus.rd_en_2, 0);
        check("t5_rd_add_2", bus.rd_add_2, 0);
        check("t5_free_2", bus.bank_free_2, 0);
        check("t5_overrun", bus.overrun, 0);
        repeat (5) tick();
        check("t5_no_free2", free2_cnt, 0);
        push_frame(200);
        pulse_rdy(1'b0, 1'b1);
        wait_done("t5_replay_done", 1'b0);
        check("t5_replay_free2", free2_cnt, 1);
        check("t5_replay_free1", free1_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
